sc_io_port_bank: RTL

//  Parametrised memory-mapped I/O port bank for the single-cycle computer.
//  It replaces fixed in_port0/1 and out_port0/1/2 wiring with N_IN input and N_OUT output ports.

---
 rtl/io_map_pkg.sv | 15 +
 rtl/sc_io_port_bank_if.sv | 14 +
 rtl/io_sync_chg.sv | 32 +++
 rtl/sc_io_port_bank.sv | 109 ++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Address map and configuration limits for the memory-mapped I/O port bank.
package io_map_pkg;

   localparam int unsigned MAX_PORTS  = 8;
   localparam logic [7:0]  OUT_BASE   = 8'h80;
   localparam logic [7:0]  IN_BASE    = 8'hC0;
   localparam logic [7:0]  STATUS_OFF = 8'hF0;
   localparam logic [7:0]  MASK_OFF   = 8'hF4;

   // True when a port count fits the address map.
   function automatic bit port_count_ok(input int unsigned n);
      return (n >= 1) && (n <= MAX_PORTS);
   endfunction

endpackage

// File: rtl/sc_io_port_bank_if.sv
// CPU-side bus between the core and the I/O port bank.
interface sc_io_port_bank_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic              re;
   logic [DATA_W-1:0] rdata;

   modport master (output addr, output wdata, output we, output re, input rdata);
   modport slave  (input addr, input wdata, input we, input re, output rdata);
endinterface

// File: rtl/io_sync_chg.sv
// Two-flop input synchroniser with a previous-value register and a change indication.
module io_sync_chg #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] pin_i,
   output logic [DATA_W-1:0] sync_o,
   output logic              chg_c
);

   logic [DATA_W-1:0] sync1_q;
   logic [DATA_W-1:0] sync2_q;
   logic [DATA_W-1:0] prev_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= pin_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign sync_o = sync2_q;
   // Any bit difference between consecutive synchronised samples counts as a change.
   assign chg_c  = (sync2_q != prev_q);

endmodule

// File: rtl/sc_io_port_bank.sv
// Memory-mapped bank of N_IN synchronised input ports and N_OUT output ports,
// with sticky per-input change flags and a masked level interrupt.
module sc_io_port_bank
   import io_map_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned N_IN   = 2,
   parameter int unsigned N_OUT  = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   sc_io_port_bank_if.slave        bus,
   input  logic [N_IN*DATA_W-1:0]  in_port,
   output logic [N_OUT*DATA_W-1:0] out_port,
   output logic                    irq
);

   if (!port_count_ok(N_IN) || !port_count_ok(N_OUT)) begin : g_cfg_err
      $error("sc_io_port_bank: N_IN and N_OUT must be in 1..8");
   end

   logic [ADDR_W-1:0] word_addr;
   logic [N_OUT-1:0]  out_hit;
   logic [N_IN-1:0]   in_hit;
   logic              status_hit;
   logic              mask_hit;

   logic [DATA_W-1:0] in_sync [N_IN];
   logic [N_IN-1:0]   chg;

   logic [DATA_W-1:0] out_q [N_OUT];
   logic [DATA_W-1:0] out_d [N_OUT];
   logic [N_IN-1:0]   mask_q, mask_d;
   logic [N_IN-1:0]   flag_q, flag_d;
   logic [N_IN-1:0]   flag_clr;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] rd_sel;

   // Word-aligned decode: the two byte-offset bits never select a register.
   assign word_addr  = bus.addr & ~ADDR_W'(3);
   assign status_hit = (word_addr == ADDR_W'(STATUS_OFF));
   assign mask_hit   = (word_addr == ADDR_W'(MASK_OFF));

   for (genvar k = 0; k < N_OUT; k++) begin : g_out
      assign out_hit[k] = (word_addr == ADDR_W'(OUT_BASE) + ADDR_W'(4 * k));
      assign out_port[k*DATA_W +: DATA_W] = out_q[k];
   end

   for (genvar k = 0; k < N_IN; k++) begin : g_in
      assign in_hit[k] = (word_addr == ADDR_W'(IN_BASE) + ADDR_W'(4 * k));

      io_sync_chg #(.DATA_W(DATA_W)) u_sync (
         .clock  (clock),
         .reset  (reset),
         .pin_i  (in_port[k*DATA_W +: DATA_W]),
         .sync_o (in_sync[k]),
         .chg_c  (chg[k])
      );
   end

   // Next-state for writable registers, sticky flags and the read mux.
   always_comb begin
      out_d    = out_q;
      mask_d   = mask_q;
      flag_clr = '0;
      rd_sel   = '0;

      if (bus.we) begin
         for (int k = 0; k < N_OUT; k++) begin
            if (out_hit[k]) out_d[k] = bus.wdata;
         end
         if (mask_hit)   mask_d   = bus.wdata[N_IN-1:0];
         if (status_hit) flag_clr = bus.wdata[N_IN-1:0];
      end

      // A new change on the same edge as a clear keeps the flag set.
      flag_d = (flag_q & ~flag_clr) | chg;

      for (int k = 0; k < N_OUT; k++) begin
         if (out_hit[k]) rd_sel = out_q[k];
      end
      for (int k = 0; k < N_IN; k++) begin
         if (in_hit[k]) rd_sel = in_sync[k];
      end
      if (status_hit) rd_sel = DATA_W'(flag_q);
      if (mask_hit)   rd_sel = DATA_W'(mask_q);

      rdata_d = bus.re ? rd_sel : rdata_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
         mask_q  <= '0;
         flag_q  <= '0;
         rdata_q <= '0;
      end else begin
         for (int k = 0; k < N_OUT; k++) out_q[k] <= out_d[k];
         mask_q  <= mask_d;
         flag_q  <= flag_d;
         rdata_q <= rdata_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign irq       = |(flag_q & mask_q);

endmodule
